// File: rtl/next_pc_unit_pkg.sv
// Shared MIPS PC-stage definitions: FSM state encoding, reset/trap vectors, jump target helper.
// Pure declarations; no logic, latency or flow control of its own.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

  // j/jal target keeps the 256 MB region of the delay-slot PC.
  function automatic logic [31:0] jump_addr(input logic [31:0] pc_plus4,
                                            input logic [25:0] instr_index);
    return {pc_plus4[31:28], instr_index, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_unit_mux.sv
// Next-PC priority select (jr > jump > taken branch > pc+4) with alignment flag.
// Purely combinational, zero latency; no flow control.
module next_pc_mux
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] branch_target,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [25:0] instr_index,
  input  logic        jr,
  input  logic [31:0] rs_value,
  output logic [31:0] candidate,
  output logic        misaligned
);

  always_comb begin
    candidate = pc_plus4;
    if (jr)
      candidate = rs_value;
    else if (jump)
      candidate = jump_addr(pc_plus4, instr_index);
    else if (branch && zero)
      candidate = branch_target;
  end

  assign misaligned = (candidate[1:0] != 2'b00);

endmodule

// File: rtl/next_pc_unit.sv
// PC register with stall/halt FSM, misaligned-target trap (EPC capture) and retired counter.
// pc updates one edge after inputs; stall holds pc/counter, HALT freezes until reset.
module next_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] branch_target,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [25:0] instr_index,
  input  logic        jr,
  input  logic [31:0] rs_value,
  input  logic        stall,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] epc,
  output logic        exc,
  output logic        halted,
  output logic [31:0] retired
);

  state_t      state;
  logic [31:0] candidate;
  logic        misaligned;

  assign pc_plus4 = pc + 32'd4;
  assign halted   = (state == ST_HALT);

  next_pc_mux u_mux (
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .branch        (branch),
    .zero          (zero),
    .jump          (jump),
    .instr_index   (instr_index),
    .jr            (jr),
    .rs_value      (rs_value),
    .candidate     (candidate),
    .misaligned    (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RUN;
      pc      <= RESET_PC;
      epc     <= 32'd0;
      exc     <= 1'b0;
      retired <= 32'd0;
    end else begin
      case (state)
        ST_RUN: begin
          exc <= 1'b0;
          if (halt_req) begin
            state <= ST_HALT;
          end else if (!stall) begin
            retired <= retired + 32'd1;
            if (misaligned) begin
              pc  <= EXC_VECTOR;
              epc <= pc;
              exc <= 1'b1;
            end else begin
              pc <= candidate;
            end
          end
        end
        ST_HALT: begin
          exc <= 1'b0;
        end
        // Unused encoding: recover to RUN without touching architectural state.
        default: begin
          state <= ST_RUN;
          exc   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed test of next_pc_unit: sequencing, branch/jump/jr priority, stall, trap, wrap, halt, reset.
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] branch_target;
  logic        branch, zero, jump, jr, stall, halt_req;
  logic [25:0] instr_index;
  logic [31:0] rs_value;
  logic [31:0] pc, pc_plus4, epc, retired;
  logic        exc, halted;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  next_pc_unit dut (
    .clk           (clk),
    .reset         (reset),
    .branch_target (branch_target),
    .branch        (branch),
    .zero          (zero),
    .jump          (jump),
    .instr_index   (instr_index),
    .jr            (jr),
    .rs_value      (rs_value),
    .stall         (stall),
    .halt_req      (halt_req),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .epc           (epc),
    .exc           (exc),
    .halted        (halted),
    .retired       (retired)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    branch = 1'b0; zero = 1'b0; jump = 1'b0; jr = 1'b0;
    stall = 1'b0; halt_req = 1'b0;
    branch_target = 32'h0; rs_value = 32'h0; instr_index = 26'h0;
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the architectural outputs after an edge.
  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ret,
                         input logic e_exc, input logic e_halted);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".retired"}, retired, e_ret);
    chk({tag, ".exc"}, {31'd0, exc}, {31'd0, e_exc});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halted});
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    chk_all("reset", 32'h0, 32'd0, 1'b0, 1'b0);
    chk("reset.epc", epc, 32'h0);
    chk("reset.pc_plus4", pc_plus4, 32'h4);
    reset = 1'b0;

    // Sequential fetch
    tick(); chk_all("seq1", 32'h4, 32'd1, 1'b0, 1'b0);
    tick(); chk_all("seq2", 32'h8, 32'd2, 1'b0, 1'b0);
    tick(); chk_all("seq3", 32'hC, 32'd3, 1'b0, 1'b0);
    tick(); chk_all("seq4", 32'h10, 32'd4, 1'b0, 1'b0);

    // Taken branch from 0x10, then not-taken branch from 0x40
    branch = 1'b1; zero = 1'b1; branch_target = 32'h40;
    tick(); chk_all("br_taken", 32'h40, 32'd5, 1'b0, 1'b0);
    zero = 1'b0; branch_target = 32'h80;
    tick(); chk_all("br_not", 32'h44, 32'd6, 1'b0, 1'b0);
    idle_inputs();

    // jr to 0x1000_0010, then jump keeps region bits of pc+4
    jr = 1'b1; rs_value = 32'h1000_0010;
    tick(); chk_all("jr1", 32'h1000_0010, 32'd7, 1'b0, 1'b0);
    idle_inputs();
    jump = 1'b1; instr_index = 26'h000_0100;
    tick(); chk_all("jump", 32'h1000_0400, 32'd8, 1'b0, 1'b0);
    // jump and jr together: jr wins; branch also asserted but lowest priority
    jr = 1'b1; rs_value = 32'h200; branch = 1'b1; zero = 1'b1; branch_target = 32'h300;
    tick(); chk_all("jr_prio", 32'h200, 32'd9, 1'b0, 1'b0);
    idle_inputs();
    // jump beats taken branch
    jump = 1'b1; instr_index = 26'h000_0005; branch = 1'b1; zero = 1'b1; branch_target = 32'h300;
    tick(); chk_all("jump_prio", 32'h0000_0014, 32'd10, 1'b0, 1'b0);
    idle_inputs();

    // Stall three cycles at 0x14, with a jump pending
    stall = 1'b1; jump = 1'b1; instr_index = 26'h3F;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("stall", 32'h14, 32'd10, 1'b0, 1'b0);
    end
    idle_inputs();

    // Misaligned jr target traps from pc=0x20
    jr = 1'b1; rs_value = 32'h20;
    tick(); chk_all("jr20", 32'h20, 32'd11, 1'b0, 1'b0);
    rs_value = 32'h202;
    tick(); chk_all("trap1", 32'h80, 32'd12, 1'b1, 1'b0);
    chk("trap1.epc", epc, 32'h20);
    idle_inputs();
    stall = 1'b1;
    tick(); chk_all("trap1_stall", 32'h80, 32'd12, 1'b0, 1'b0);
    idle_inputs();
    tick(); chk_all("after_trap", 32'h84, 32'd13, 1'b0, 1'b0);

    // Misaligned branch target, then back-to-back trap keeps exc high
    branch = 1'b1; zero = 1'b1; branch_target = 32'h43;
    tick(); chk_all("trap_br", 32'h80, 32'd14, 1'b1, 1'b0);
    chk("trap_br.epc", epc, 32'h84);
    idle_inputs();
    jr = 1'b1; rs_value = 32'h1;
    tick(); chk_all("trap_b2b", 32'h80, 32'd15, 1'b1, 1'b0);
    chk("trap_b2b.epc", epc, 32'h80);
    idle_inputs();
    tick(); chk_all("exc_clear", 32'h84, 32'd16, 1'b0, 1'b0);
    chk("exc_clear.epc", epc, 32'h80);

    // PC wrap at top of address space
    jr = 1'b1; rs_value = 32'hFFFF_FFFC;
    tick(); chk_all("pc_top", 32'hFFFF_FFFC, 32'd17, 1'b0, 1'b0);
    chk("pc_top.plus4", pc_plus4, 32'h0);
    idle_inputs();
    tick(); chk_all("pc_wrap", 32'h0, 32'd18, 1'b0, 1'b0);

    // Jump from region 0 with all-ones index
    jump = 1'b1; instr_index = 26'h3FF_FFFF;
    tick(); chk_all("jump_max", 32'h0FFF_FFFC, 32'd19, 1'b0, 1'b0);
    idle_inputs();

    // Trap, then halt (with stall) on the next edge: exc must drop, state frozen
    jr = 1'b1; rs_value = 32'h6;
    tick(); chk_all("trap3", 32'h80, 32'd20, 1'b1, 1'b0);
    chk("trap3.epc", epc, 32'h0FFF_FFFC);
    idle_inputs();
    stall = 1'b1; halt_req = 1'b1;
    tick(); chk_all("halt", 32'h80, 32'd20, 1'b0, 1'b1);
    idle_inputs();
    jump = 1'b1; instr_index = 26'h123; jr = 1'b1; rs_value = 32'h3;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("halt_hold", 32'h80, 32'd20, 1'b0, 1'b1);
      chk("halt_hold.epc", epc, 32'h0FFF_FFFC);
    end
    idle_inputs();

    // Reset leaves HALT
    reset = 1'b1;
    tick(); chk_all("reset2", 32'h0, 32'd0, 1'b0, 1'b0);
    chk("reset2.epc", epc, 32'h0);
    reset = 1'b0;
    tick(); chk_all("run_again", 32'h4, 32'd1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
